// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM states, sizing
// constants and the rotating find-first search used for every arbitration.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Result of one arbitration: whether anyone won, and who.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Search req starting at index ptr, wrapping 3->0, ignoring bits set in
  // excl. Walking the offsets from farthest to nearest lets the nearest
  // set bit overwrite the result, so the first hit after ptr wins.
  function automatic rr_pick_t rr_find(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   ptr,
                                       input logic [NUM_REQ-1:0] excl);
    rr_pick_t             pick;
    logic [NUM_REQ-1:0]   masked;
    logic [SEL_W-1:0]     k;
    pick.found = 1'b0;
    pick.idx   = '0;
    masked     = req & ~excl;
    for (int n = NUM_REQ - 1; n >= 0; n--) begin
      k = ptr + SEL_W'(n);
      if (masked[k]) begin
        pick.found = 1'b1;
        pick.idx   = k;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// 2-to-4 select decode with enable: turns the owner index into the one-hot
// grant/enable vector, all-zero when no grant is active.
module grant_decoder
  import arb_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  // One comparator per output line; at most one can match a given sel.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
    assign gnt[gi] = en && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 output mux.
// Grants one requester at a time, hands off with no idle bubble, and drives
// the select, one-hot enables and the gated output data.
// Optional feature macro ARB_TIMEOUT_EN: limits an owner to HOLD_MAX
// consecutive grant cycles while somebody else is waiting.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int DW       = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          valid,
  output logic [DW-1:0] out
);

  // A zero hold limit would make the timeout counter meaningless.
  if (HOLD_MAX < 1) begin : g_hold_max_invalid
    $error("rr_mux_arbiter: HOLD_MAX must be at least 1");
  end

  arb_state_t         state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               valid_reg, valid_next;

  logic [NUM_REQ-1:0] own_mask;
  logic               hold_expired;
  logic               rel;
  rr_pick_t           pick_idle;
  rr_pick_t           pick_rel;

  // One-hot mask of the current owner, used to exclude it on release.
  always_comb begin
    own_mask          = '0;
    own_mask[sel_reg] = 1'b1;
  end

  // The owner gives up the line when it drops its request or its hold
  // time has run out with someone else waiting.
  assign rel = (state_reg == GRANT) && (!req[sel_reg] || hold_expired);

  // From idle, search from the priority pointer; on release, search from
  // the slot after the old owner with the old owner excluded.
  assign pick_idle = rr_find(req, ptr_reg, '0);
  assign pick_rel  = rr_find(req, sel_reg + SEL_W'(1), own_mask);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Count grant cycles of the current owner, saturating at the limit;
  // every release (with or without a new owner) starts a fresh count.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg != GRANT || rel) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_LAST) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign hold_expired = (cnt_reg == CNT_LAST) && (|(req & ~own_mask));

  // Hold-time counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // Next-state logic: grant from idle, hold, or release with same-edge
  // re-arbitration so a waiting requester takes over with no dead cycle.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (pick_idle.found) begin
          state_next = GRANT;
          sel_next   = pick_idle.idx;
          valid_next = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_next = sel_reg + SEL_W'(1);
          if (pick_rel.found) begin
            sel_next = pick_rel.idx;
          end else begin
            state_next = IDLE;
            valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
    end
  end

  grant_decoder u_grant_decoder (
    .sel (sel_reg),
    .en  (valid_reg),
    .gnt (gnt)
  );

  logic [DW-1:0] din [NUM_REQ];
  assign din[0] = i0;
  assign din[1] = i1;
  assign din[2] = i2;
  assign din[3] = i3;

  // Output follows the registered owner only, so it never mixes sources.
  assign out   = valid_reg ? din[sel_reg] : '0;
  assign sel   = sel_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter. Each cycle the bench drives req,
// rst and fresh random data, pushes the expected grant/output for after the
// next edge, then pops and compares 1 time unit after that edge.
// Timeout scenarios are exercised when ARB_TIMEOUT_EN is defined.
module tb_rr_mux_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] d [4];
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          valid;
  logic [DW-1:0] out;

  typedef struct {
    logic          valid;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          sel_care;
    logic [DW-1:0] out;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic       rst;
    int         owner;   // -1 = no grant expected
  } row_t;

  exp_t sb[$];
  int   ncmp  = 0;
  int   nfail = 0;

  rr_mux_arbiter #(.DW(DW), .HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .i0    (d[0]),
    .i1    (d[1]),
    .i2    (d[2]),
    .i3    (d[3]),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, record what must appear after the edge.
  task automatic cyc(input logic [3:0] r, input logic rr, input int owner);
    exp_t e;
    req = r;
    rst = rr;
    for (int k = 0; k < 4; k++) d[k] = DW'($urandom);
    e.valid    = (owner >= 0);
    e.gnt      = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
    e.sel      = (owner >= 0) ? owner[1:0] : 2'b00;
    e.sel_care = (owner >= 0) || rr;
    e.out      = (owner >= 0) ? d[owner] : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows [3];
    exp_t e;
    rows = '{'{4'b0000, 1'b1, -1}, '{4'b0000, 1'b1, -1}, '{4'b0000, 1'b0, -1}};
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL reset row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL reset row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("reset row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask

  task automatic test_single();
    row_t rows [7];
    exp_t e;
    rows = '{'{4'b0100, 1'b0, 2}, '{4'b0100, 1'b0, 2}, '{4'b0100, 1'b0, 2},
             '{4'b0100, 1'b0, 2}, '{4'b0100, 1'b0, 2}, '{4'b0100, 1'b0, 2},
             '{4'b0000, 1'b0, -1}};
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL single row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL single row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("single row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask

  // Every requester asks; each owner drops for one cycle after two granted
  // cycles. Expected order 0,1,2,3,0 with no idle cycle between owners.
  task automatic test_rotation();
    row_t rows [11];
    exp_t e;
    rows = '{'{4'b0000, 1'b1, -1},
             '{4'b1111, 1'b0, 0}, '{4'b1111, 1'b0, 0},
             '{4'b1110, 1'b0, 1}, '{4'b1111, 1'b0, 1},
             '{4'b1101, 1'b0, 2}, '{4'b1111, 1'b0, 2},
             '{4'b1011, 1'b0, 3}, '{4'b1111, 1'b0, 3},
             '{4'b0111, 1'b0, 0}, '{4'b1111, 1'b0, 0}};
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL rotation row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL rotation row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("rotation row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask

  // Owner 0 hands to 3, owner 3 drops to idle (ptr wraps to 0), then 1001
  // must go to 0, and 0 dropping with 3 still waiting hands straight to 3.
  task automatic test_idle_handoff();
    row_t rows [7];
    exp_t e;
    rows = '{'{4'b1000, 1'b0, 3}, '{4'b1000, 1'b0, 3},
             '{4'b0000, 1'b0, -1},
             '{4'b1001, 1'b0, 0}, '{4'b1001, 1'b0, 0},
             '{4'b1000, 1'b0, 3}, '{4'b0000, 1'b0, -1}};
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL handoff row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL handoff row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("handoff row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask

  // Build ptr=2 with owner 1 granted, reset mid-grant, then 0110 must go
  // to 1 (it would go to 2 had the pointer survived the reset).
  task automatic test_mid_reset();
    row_t rows [7];
    exp_t e;
    rows = '{'{4'b0010, 1'b0, 1}, '{4'b0000, 1'b0, -1},
             '{4'b0010, 1'b0, 1}, '{4'b0010, 1'b0, 1},
             '{4'b0010, 1'b1, -1},
             '{4'b0110, 1'b0, 1}, '{4'b0000, 1'b0, -1}};
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL midreset row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL midreset row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("midreset row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  // HOLD_MAX=8: 0011 alternates owners every 8 cycles; 0001 alone holds
  // past the limit, and a late competitor preempts on its first cycle.
  task automatic test_timeout();
    row_t rows [$];
    exp_t e;
    rows.push_back('{4'b0000, 1'b1, -1});
    for (int t = 0; t < 34; t++) rows.push_back('{4'b0011, 1'b0, (t / 8) % 2});
    rows.push_back('{4'b0000, 1'b1, -1});
    for (int t = 0; t < 12; t++) rows.push_back('{4'b0001, 1'b0, 0});
    rows.push_back('{4'b0011, 1'b0, 1});
    rows.push_back('{4'b0000, 1'b0, -1});
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL timeout row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL timeout row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("timeout row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask
`else
  // Without the timeout, owner 0 keeps the line under contention until it
  // drops its own request.
  task automatic test_hold_forever();
    row_t rows [$];
    exp_t e;
    rows.push_back('{4'b0000, 1'b1, -1});
    for (int t = 0; t < 20; t++) rows.push_back('{4'b0011, 1'b0, 0});
    rows.push_back('{4'b0010, 1'b0, 1});
    rows.push_back('{4'b0000, 1'b0, -1});
    foreach (rows[n]) begin
      cyc(rows[n].req, rows[n].rst, rows[n].owner);
      if (sb.size() == 0) begin
        nfail++; $display("FAIL hold row %0d: scoreboard empty", n);
      end else begin
        e = sb.pop_front(); ncmp++;
        if (valid !== e.valid || gnt !== e.gnt || out !== e.out || (e.sel_care && sel !== e.sel)) begin
          nfail++;
          $display("FAIL hold row %0d: got valid=%b gnt=%b sel=%b out=%h, want valid=%b gnt=%b sel=%b out=%h",
                   n, valid, gnt, sel, out, e.valid, e.gnt, e.sel, e.out);
        end
      end
      $display("hold row %0d: req=%b gnt=%b sel=%b valid=%b out=%h", n, req, gnt, sel, valid, out);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int k = 0; k < 4; k++) d[k] = '0;
    test_reset();
    test_single();
    test_rotation();
    test_idle_handoff();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

- Round-robin arbiter and sequencer for the shared 4:1 selection datapath (2-to-4 select decode feeding four gated input drivers onto one output).
- Accepts up to four requesters and grants the output to one at a time.
- Drives the 2-bit select and one-hot enables, and presents the selected data on a single registered-select output.
- Sits between requester logic and the shared output line, so enables never overlap.

## Interface
Parameters:
- DW, 1, data width of each input and of `out`
- HOLD_MAX, 8, maximum consecutive grant cycles per owner (used only with ARB_TIMEOUT_EN)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset: synchronous, active-high
- req  input  4  request per requester; req[k] pairs with input ik
- i0, i1, i2, i3  input  DW each  requester data
- gnt  output  4  one-hot grant (all-zero when idle)
- sel  output  2  {s1,s0} index of current owner
- valid  output  1  high while a grant is active
- out  output  DW  selected data: i[sel] when valid, else all-zero

## Operation
- States: IDLE, GRANT.
- Registers: state, ptr (2-bit priority start), sel, gnt, valid, and cnt (timeout only).
- Arbitration: search req from index ptr upward, wrapping 3→0; first set bit wins.
- IDLE:
  - gnt=0, valid=0.
  - If any req bit is set at an edge, go to GRANT with sel=winner, gnt=1<<winner, valid=1.
- GRANT:
  - Hold while req[sel]=1.
  - On an edge where req[sel]=0, release: ptr←sel+1 (mod 4). Re-arbitrate the remaining req bits in the same edge.
  - If a winner exists, go directly to GRANT with the new owner (no idle bubble). Otherwise go to IDLE.
- A dropped owner re-requesting in the release edge is excluded from that edge's arbitration.
- `out` is combinational from registered sel/valid: a 4:1 mux of i0..i3, gated to zero when valid=0. It never carries two sources.
- gnt is always one-hot or zero and always equals decode(sel) while valid=1.

## Timing
- Reset (rst=1 at an edge), all registers: state=IDLE, ptr=0, sel=0, gnt=0, valid=0, cnt=0. Output `out`=0.
- Reset asserted mid-grant drops gnt/valid at that edge; no other state survives.
- Grant latency: req sampled at edge N → gnt/valid high after edge N; `out` is valid in that cycle.
- Release latency: req[sel] low at edge N → old gnt bit low after edge N. The new owner's gnt is high after the same edge.
- Simultaneous requests: priority rotates from ptr. After owner k releases, k has lowest priority next.
- Back-to-back handoff has zero dead cycles.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - cnt counts GRANT cycles for the current owner. It clears on every new grant.
  - When cnt=HOLD_MAX-1 and any other req bit is set, force release at that edge as if req[sel] dropped: ptr←sel+1, re-arbitrate excluding the owner.
  - If no other requester exists, the owner keeps the grant and cnt saturates at HOLD_MAX-1. Preemption then happens at the first edge another req appears.
- Undefined: no cnt register. The owner holds indefinitely until req[sel] drops.

## Structure
- Shared package `arb_pkg`: state enum (IDLE, GRANT), NUM_REQ=4, SEL_W=2, and a round-robin find-first function (req, ptr, exclude mask).
- One sub-module, `grant_decoder`: 2-to-4 decode with enable, producing gnt from sel and valid.

## Test plan
- Reset then idle: rst=1 for 2 cycles, req=0 → gnt=0000, sel=00, valid=0, out=0.
- Single request: req=0100, i2=1 → next edge gnt=0100, sel=10, valid=1, out=1. Held 5 cycles while req stays set.
- Contention rotation: req=1111 held, each owner drops req for 1 cycle after 2 cycles → grant order 0,1,2,3,0, with zero idle cycles between grants.
- Handoff to idle: owner 3 drops with req=0000 → valid=0, gnt=0000 after the edge. Next req=1001 grants index 0 (ptr=0 after wrap).
- Mid-grant reset: owner 1 granted, rst=1 one cycle → gnt=0000, ptr=0. With req=0110 after reset, grant goes to index 1.
- ARB_TIMEOUT_EN, HOLD_MAX=8: req=0011 constant → owner 0 for exactly 8 cycles, then owner 1 for 8 cycles, alternating. With req=0001 alone, owner 0 holds beyond 8 cycles.
